// File: rtl/slave_in_if.sv
// Bus bundle between a serial master and the slave_in block, plus the
// slave's local memory port.
//
// Handshake: the master drives one bit per cycle on every tx_* line and
// holds master_valid high for each cycle whose bits are meaningful; a cycle
// with master_valid low carries nothing.  slave_ready is high only while the
// slave is idle and able to take bit 0 of a new header.  On the read return
// path rx_data is meaningful only in cycles where slave_valid is high; there
// is no backpressure on that path.  rx_done pulses for one cycle when a
// transaction addressed to this slave finishes.  mem_we/mem_re are single
// cycle strobes; mem_rdata must be valid the cycle after mem_re.
interface slave_in_if;
    logic        master_valid;
    logic        tx_slave_select;
    logic        tx_address;
    logic        tx_burst_number;
    logic        tx_data;
    logic        write_en;
    logic        read_en;

    logic        slave_ready;
    logic        rx_done;
    logic        slave_valid;
    logic        rx_data;

    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    // Slave side: consumes the serial request and the memory read data.
    modport slave (
        input  master_valid,
        input  tx_slave_select,
        input  tx_address,
        input  tx_burst_number,
        input  tx_data,
        input  write_en,
        input  read_en,
        input  mem_rdata,
        output slave_ready,
        output rx_done,
        output slave_valid,
        output rx_data,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re
    );

    // Master side, including the memory model that answers mem_re.
    modport master (
        output master_valid,
        output tx_slave_select,
        output tx_address,
        output tx_burst_number,
        output tx_data,
        output write_en,
        output read_en,
        output mem_rdata,
        input  slave_ready,
        input  rx_done,
        input  slave_valid,
        input  rx_data,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re
    );
endinterface

// File: rtl/slave_in.sv
// Serial bus slave: deserialises a 12-cycle header (select, start address,
// burst count), then either collects write bytes and strobes them into local
// memory, or fetches bytes from local memory and serialises them back.
// Bursts walk the address upward and wrap at 4095 -> 0.
module slave_in #(
    parameter logic [1:0] SLAVE_ID = 2'b10
) (
    input  logic             clk,
    input  logic             reset,
    slave_in_if.slave        bus,
    output logic [3:0]       dbg_state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HEADER  = 4'd1;
    localparam logic [3:0] S_IGNORE  = 4'd2;
    localparam logic [3:0] S_WDATA   = 4'd3;
    localparam logic [3:0] S_WSTROBE = 4'd4;
    localparam logic [3:0] S_RREQ    = 4'd5;
    localparam logic [3:0] S_RWAIT   = 4'd6;
    localparam logic [3:0] S_RSHIFT  = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]  state_q,   state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic [1:0]  sel_q,     sel_d;
    logic [11:0] base_q,    base_d;
    logic [11:0] burst_q,   burst_d;
    logic        we_q,      we_d;
    logic        re_q,      re_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [12:0] beat_q,    beat_d;
    logic [7:0]  wbyte_q,   wbyte_d;
    logic [7:0]  rbyte_q,   rbyte_d;

    logic        clear_fields;
    logic        last_beat;
    logic        hdr_match;
    logic [11:0] beat_addr;

    // Beat index is 13 bits so a burst count of 4095 gives 4096 beats; the
    // address only uses the low 12 bits and wraps naturally.
    assign last_beat = (beat_q == {1'b0, burst_q});
    assign beat_addr = base_q + beat_q[11:0];
    assign hdr_match = (sel_q == SLAVE_ID) && (we_q != re_q);

    // Next-state and datapath update for the whole transaction sequence.
    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        sel_d        = sel_q;
        base_d       = base_q;
        burst_d      = burst_q;
        we_d         = we_q;
        re_d         = re_q;
        bit_cnt_d    = bit_cnt_q;
        beat_d       = beat_q;
        wbyte_d      = wbyte_q;
        rbyte_d      = rbyte_q;
        clear_fields = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.master_valid) begin
                    // Header bit 0 and the operation type arrive together.
                    hdr_cnt_d = 4'd1;
                    sel_d     = {1'b0, bus.tx_slave_select};
                    base_d    = {11'd0, bus.tx_address};
                    burst_d   = {11'd0, bus.tx_burst_number};
                    we_d      = bus.write_en;
                    re_d      = bus.read_en;
                    bit_cnt_d = 3'd0;
                    beat_d    = 13'd0;
                    wbyte_d   = 8'd0;
                    rbyte_d   = 8'd0;
                    state_d   = S_HEADER;
                end
            end

            S_HEADER: begin
                if (!bus.master_valid) begin
                    // A gap inside the header means the master gave up.
                    clear_fields = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    if (hdr_cnt_q == 4'd1) begin
                        sel_d[1] = bus.tx_slave_select;
                    end
                    base_d[hdr_cnt_q]  = bus.tx_address;
                    burst_d[hdr_cnt_q] = bus.tx_burst_number;
                    hdr_cnt_d          = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd11) begin
                        // Select bits landed in cycles 0-1, so the decision
                        // can use the registered copy.
                        hdr_cnt_d = 4'd0;
                        if (!hdr_match) begin
                            state_d = S_IGNORE;
                        end else if (we_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_RREQ;
                        end
                    end
                end
            end

            S_IGNORE: begin
                // Sit out the rest of someone else's transaction.
                if (!bus.master_valid) begin
                    clear_fields = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            S_WDATA: begin
                if (bus.master_valid) begin
                    wbyte_d[bit_cnt_q] = bus.tx_data;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_WSTROBE;
                    end
                end
            end

            S_WSTROBE: begin
                if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + 13'd1;
                    state_d = S_WDATA;
                end
            end

            S_RREQ: begin
                state_d = S_RWAIT;
            end

            S_RWAIT: begin
                rbyte_d   = bus.mem_rdata;
                bit_cnt_d = 3'd0;
                state_d   = S_RSHIFT;
            end

            S_RSHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 13'd1;
                        state_d = S_RREQ;
                    end
                end
            end

            S_DONE: begin
                clear_fields = 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                clear_fields = 1'b1;
                state_d      = S_IDLE;
            end
        endcase

        // Leaving a transaction returns every field to its idle value.
        if (clear_fields) begin
            hdr_cnt_d = 4'd0;
            sel_d     = 2'd0;
            base_d    = 12'd0;
            burst_d   = 12'd0;
            we_d      = 1'b0;
            re_d      = 1'b0;
            bit_cnt_d = 3'd0;
            beat_d    = 13'd0;
            wbyte_d   = 8'd0;
            rbyte_d   = 8'd0;
        end
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= 4'd0;
            sel_q     <= 2'd0;
            base_q    <= 12'd0;
            burst_q   <= 12'd0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            bit_cnt_q <= 3'd0;
            beat_q    <= 13'd0;
            wbyte_q   <= 8'd0;
            rbyte_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            sel_q     <= sel_d;
            base_q    <= base_d;
            burst_q   <= burst_d;
            we_q      <= we_d;
            re_q      <= re_d;
            bit_cnt_q <= bit_cnt_d;
            beat_q    <= beat_d;
            wbyte_q   <= wbyte_d;
            rbyte_q   <= rbyte_d;
        end
    end

    // Outputs decode directly from the state register, so they follow an
    // asynchronous reset without waiting for a clock edge.  Strobes are
    // tied to mutually exclusive states and can never overlap.
    assign bus.slave_ready = (state_q == S_IDLE);
    assign bus.rx_done     = (state_q == S_DONE);
    assign bus.slave_valid = (state_q == S_RSHIFT);
    assign bus.rx_data     = (state_q == S_RSHIFT) ? rbyte_q[bit_cnt_q] : 1'b0;
    assign bus.mem_we      = (state_q == S_WSTROBE);
    assign bus.mem_re      = (state_q == S_RREQ);
    assign bus.mem_addr    = ((state_q == S_WSTROBE) || (state_q == S_RREQ)) ? beat_addr : 12'd0;
    assign bus.mem_wdata   = (state_q == S_WSTROBE) ? wbyte_q : 8'd0;
    assign dbg_state       = state_q;

endmodule
